// File: rtl/tlul_host_arbiter.sv
// Round-robin TL-UL arbiter: NumHosts host ports share one device port. A requests are forwarded
// combinationally; an in-order grant FIFO routes D responses back to their originating host.

package tlul_pkg;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

module tlul_host_arbiter
  import tlul_pkg::*;
#(
  parameter int unsigned NumHosts       = 2,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  tl_h2d_t tl_h_i [NumHosts],
  output tl_d2h_t tl_h_o [NumHosts],
  output tl_h2d_t tl_d_o,
  input  tl_d2h_t tl_d_i,
  output logic    busy_o
);

  localparam int unsigned IdxW = (NumHosts > 1) ? $clog2(NumHosts) : 1;
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic            lock_valid_q, lock_valid_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;
  logic [IdxW-1:0] fifo_q [MaxOutstanding];
  logic [IdxW-1:0] fifo_d [MaxOutstanding];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            pick_valid;
  logic [IdxW-1:0] pick_idx, cand;
  logic [IdxW-1:0] grant_idx, head_idx;
  logic            grant_valid, fifo_full, fifo_nonempty;
  logic            a_valid_o, d_ready_o, accept, complete;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  // First requesting host at or above rr_ptr, wrapping around.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = rr_ptr_q;
    cand       = '0;
    for (int unsigned i = 0; i < NumHosts; i++) begin
      cand = IdxW'((32'(rr_ptr_q) + i) % NumHosts);
      if (!pick_valid && tl_h_i[cand].a_valid) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign fifo_full     = (cnt_q == CntW'(MaxOutstanding));
  assign fifo_nonempty = (cnt_q != '0);
  assign head_idx      = fifo_q[rptr_q];
  assign grant_idx     = lock_valid_q ? lock_idx_q : pick_idx;
  // Outputs are quiesced while reset is held so nothing is offered to the device.
  assign grant_valid   = rst_ni && !fifo_full && (lock_valid_q || pick_valid);
  assign a_valid_o     = grant_valid && tl_h_i[grant_idx].a_valid;
  assign d_ready_o     = fifo_nonempty && tl_h_i[head_idx].d_ready;
  assign accept        = a_valid_o && tl_d_i.a_ready;
  assign complete      = tl_d_i.d_valid && d_ready_o;
  assign busy_o        = fifo_nonempty;

  always_comb begin
    tl_d_o = '0;
    if (grant_valid) begin
      tl_d_o = tl_h_i[grant_idx];
    end
    tl_d_o.a_valid = a_valid_o;
    tl_d_o.d_ready = d_ready_o;
    for (int unsigned h = 0; h < NumHosts; h++) begin
      tl_h_o[h]         = tl_d_i;
      tl_h_o[h].a_ready = grant_valid && (grant_idx == IdxW'(h)) && tl_d_i.a_ready;
      tl_h_o[h].d_valid = fifo_nonempty && (head_idx == IdxW'(h)) && tl_d_i.d_valid;
    end
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    lock_valid_d = lock_valid_q;
    lock_idx_d   = lock_idx_q;
    fifo_d       = fifo_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    cnt_d        = cnt_q;
    if (accept) begin
      rr_ptr_d       = (grant_idx == IdxW'(NumHosts - 1)) ? '0 : grant_idx + 1'b1;
      lock_valid_d   = 1'b0;
      fifo_d[wptr_q] = grant_idx;
      wptr_d         = ptr_inc(wptr_q);
    end else if (a_valid_o) begin
      // Stalled beat: pin the grant so the offered request stays stable.
      lock_valid_d = 1'b1;
      lock_idx_d   = grant_idx;
    end
    if (complete) begin
      rptr_d = ptr_inc(rptr_q);
    end
    case ({accept, complete})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q     <= '0;
      lock_valid_q <= 1'b0;
      lock_idx_q   <= '0;
      fifo_q       <= '{default: '0};
      wptr_q       <= '0;
      rptr_q       <= '0;
      cnt_q        <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      lock_valid_q <= lock_valid_d;
      lock_idx_q   <= lock_idx_d;
      fifo_q       <= fifo_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      cnt_q        <= cnt_d;
    end
  end

`ifndef SYNTHESIS
  d_valid_without_request: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(tl_d_i.d_valid && !fifo_nonempty));
`endif

endmodule

// File: tb/tb_tlul_host_arbiter.sv
// Randomized and directed bench for tlul_host_arbiter, checked every cycle against a
// queue-based model of grant order and in-order response routing.

module tb_tlul_host_arbiter;
  import tlul_pkg::*;

  localparam int N = 3;
  localparam int M = 2;

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  tl_h2d_t tl_h_i [N];
  tl_d2h_t tl_h_o [N];
  tl_h2d_t tl_d_o;
  tl_d2h_t tl_d_i;
  logic    busy;

  bit          h_valid  [N];
  logic [31:0] h_addr   [N];
  bit          h_dready [N];
  bit          dev_aready, dev_dvalid;
  logic [31:0] dev_ddata;

  int tests = 0;
  int fails = 0;
  int req_pct, ar_pct, dv_pct, drdy_pct;

  typedef struct {
    int          host;
    logic [31:0] data;
  } pend_t;

  // Model state: round-robin start, pending lock and outstanding host order.
  int m_rr;
  bit m_lock;
  int m_lock_idx;
  int m_q[$];

  // Stimulus bookkeeping fed from observed handshakes.
  bit          h_acc [N];
  bit          dev_cmp_f;
  logic [31:0] dq[$];
  pend_t       pend[$];
  int          grant_log[$];
  int          rx_log[$];

  tlul_host_arbiter #(
    .NumHosts      (N),
    .MaxOutstanding(M)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .tl_h_i(tl_h_i),
    .tl_h_o(tl_h_o),
    .tl_d_o(tl_d_o),
    .tl_d_i(tl_d_i),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int h = 0; h < N; h++) begin
      tl_h_i[h]           = '0;
      tl_h_i[h].a_valid   = h_valid[h];
      tl_h_i[h].a_opcode  = 3'd4;
      tl_h_i[h].a_size    = 2'd2;
      tl_h_i[h].a_mask    = 4'hf;
      tl_h_i[h].a_source  = 8'(h);
      tl_h_i[h].a_address = h_addr[h];
      tl_h_i[h].a_data    = ~h_addr[h];
      tl_h_i[h].d_ready   = h_dready[h];
    end
    tl_d_i          = '0;
    tl_d_i.a_ready  = dev_aready;
    tl_d_i.d_valid  = dev_dvalid;
    tl_d_i.d_opcode = 3'd1;
    tl_d_i.d_data   = dev_ddata;
  end

  function automatic logic [31:0] resp(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a5a_0f0f;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s @%0t: condition not reached", name, $time);
  endtask

  always begin : compare
    int g, head, pi;
    bit full, exp_av, acc, cmp, exp_dr, was_rst;
    @(negedge clk);
    was_rst = !rst_n;
    acc = 1'b0;
    cmp = 1'b0;
    g = -1;
    if (!rst_n) begin
      chk1("rst a_valid", tl_d_o.a_valid, 1'b0);
      chk1("rst d_ready", tl_d_o.d_ready, 1'b0);
      chk1("rst busy", busy, 1'b0);
      for (int h = 0; h < N; h++) begin
        chk1("rst a_ready", tl_h_o[h].a_ready, 1'b0);
        chk1("rst d_valid", tl_h_o[h].d_valid, 1'b0);
        h_acc[h] = 1'b0;
      end
      dev_cmp_f = 1'b0;
      m_rr = 0;
      m_lock = 1'b0;
      m_lock_idx = 0;
      m_q.delete();
    end else begin
      full = (m_q.size() >= M);
      if (!full) begin
        if (m_lock) g = m_lock_idx;
        else begin
          for (int k = 0; k < N; k++) begin
            if (g < 0 && h_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
          end
        end
      end
      exp_av = (g >= 0) && h_valid[g];
      acc = exp_av && dev_aready;
      chk1("a_valid", tl_d_o.a_valid, exp_av);
      if (exp_av) begin
        chk32("a_address", tl_d_o.a_address, h_addr[g]);
        chk32("a_source", 32'(tl_d_o.a_source), 32'(g));
      end
      for (int h = 0; h < N; h++) begin
        chk1("a_ready", tl_h_o[h].a_ready, (g == h) && dev_aready);
      end
      head = (m_q.size() > 0) ? m_q[0] : -1;
      exp_dr = (head >= 0) && h_dready[head];
      cmp = dev_dvalid && exp_dr;
      chk1("d_ready", tl_d_o.d_ready, exp_dr);
      for (int h = 0; h < N; h++) begin
        chk1("d_valid", tl_h_o[h].d_valid, (head == h) && dev_dvalid);
        if (head == h && dev_dvalid) chk32("d_data", tl_h_o[h].d_data, dev_ddata);
      end
      chk1("busy", busy, m_q.size() != 0);

      for (int h = 0; h < N; h++) begin
        h_acc[h] = h_valid[h] && tl_h_o[h].a_ready;
        if (h_acc[h]) begin
          pend.push_back('{host: h, data: resp(h_addr[h])});
          grant_log.push_back(h);
        end
      end
      if (tl_d_o.a_valid && tl_d_i.a_ready) dq.push_back(resp(tl_d_o.a_address));
      dev_cmp_f = tl_d_i.d_valid && tl_d_o.d_ready;
      if (dev_cmp_f && dq.size() > 0) void'(dq.pop_front());
      for (int h = 0; h < N; h++) begin
        if (tl_h_o[h].d_valid && h_dready[h]) begin
          rx_log.push_back(h);
          pi = -1;
          for (int i = 0; i < pend.size(); i++) if (pi < 0 && pend[i].host == h) pi = i;
          if (pi < 0) fail_now("rx without request");
          else begin
            chk32("rx data", tl_h_o[h].d_data, pend[pi].data);
            pend.delete(pi);
          end
        end
      end
    end
    @(posedge clk);
    if (rst_n && !was_rst) begin
      if (cmp) void'(m_q.pop_front());
      if (acc) begin
        m_q.push_back(g);
        m_rr = (g + 1) % N;
        m_lock = 1'b0;
      end else if (exp_av) begin
        m_lock = 1'b1;
        m_lock_idx = g;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_auto();
    for (int h = 0; h < N; h++) begin
      if (h_valid[h] && h_acc[h]) h_valid[h] = 1'b0;
      if (!h_valid[h] && ($urandom_range(99) < req_pct)) begin
        h_valid[h] = 1'b1;
        h_addr[h]  = $urandom;
      end
      h_dready[h] = $urandom_range(99) < drdy_pct;
    end
    dev_aready = $urandom_range(99) < ar_pct;
    if (!(dev_dvalid && !dev_cmp_f)) begin
      dev_dvalid = 1'b0;
      if (dq.size() > 0 && $urandom_range(99) < dv_pct) begin
        dev_dvalid = 1'b1;
        dev_ddata  = dq[0];
      end
    end
  endtask

  task automatic drain();
    bit done;
    req_pct = 0; ar_pct = 100; dv_pct = 100; drdy_pct = 100;
    done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      drive_auto();
      step();
      done = !h_valid[0] && !h_valid[1] && !h_valid[2] && !busy && dq.size() == 0 && !dev_dvalid;
    end
    if (!done) fail_now("drain timeout");
  endtask

  initial begin
    int exp_order[6];
    exp_order = '{0, 1, 2, 0, 1, 2};
    for (int h = 0; h < N; h++) begin
      h_valid[h] = 1'b0; h_addr[h] = '0; h_dready[h] = 1'b0;
    end
    dev_aready = 1'b0; dev_dvalid = 1'b0; dev_ddata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Fairness: all hosts always requesting, device always ready with 1-cycle responses.
    grant_log.delete(); rx_log.delete();
    req_pct = 100; ar_pct = 100; dv_pct = 100; drdy_pct = 100;
    for (int c = 0; c < 40 && rx_log.size() < 6; c++) begin
      drive_auto();
      step();
    end
    if (rx_log.size() < 6 || grant_log.size() < 6) fail_now("fairness beats");
    else begin
      for (int i = 0; i < 6; i++) begin
        chk32("rr grant order", 32'(grant_log[i]), 32'(exp_order[i]));
        chk32("rr response order", 32'(rx_log[i]), 32'(exp_order[i]));
      end
    end
    drain();

    // Stall lock: host 0 held four cycles while host 1 joins in cycle 2.
    for (int h = 0; h < N; h++) h_dready[h] = 1'b1;
    h_valid[0] = 1'b1; h_addr[0] = 32'h0000_1000; dev_aready = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 2) begin h_valid[1] = 1'b1; h_addr[1] = 32'h0000_2000; end
      if (c == 4) dev_aready = 1'b1;
      @(negedge clk);
      chk32("stall address", tl_d_o.a_address, 32'h0000_1000);
      chk1("stall h1 a_ready", tl_h_o[1].a_ready, 1'b0);
      step();
    end
    h_valid[0] = 1'b0;
    @(negedge clk);
    chk1("post-stall h1 grant", tl_h_o[1].a_ready, 1'b1);
    chk32("post-stall address", tl_d_o.a_address, 32'h0000_2000);
    step();
    h_valid[1] = 1'b0;
    drain();

    // FIFO full, then head host withholding d_ready.
    dev_aready = 1'b1; dev_dvalid = 1'b0;
    h_valid[0] = 1'b1; h_addr[0] = 32'h0000_3000;
    @(negedge clk); chk1("full acc0", tl_h_o[0].a_ready, 1'b1);
    step(); h_valid[0] = 1'b0;
    h_valid[1] = 1'b1; h_addr[1] = 32'h0000_3100;
    @(negedge clk); chk1("full acc1", tl_h_o[1].a_ready, 1'b1);
    step(); h_valid[1] = 1'b0;
    h_valid[2] = 1'b1; h_addr[2] = 32'h0000_3200; h_dready[0] = 1'b0;
    @(negedge clk);
    for (int h = 0; h < N; h++) chk1("full a_ready", tl_h_o[h].a_ready, 1'b0);
    chk1("full a_valid", tl_d_o.a_valid, 1'b0);
    chk1("full busy", busy, 1'b1);
    step();
    dev_dvalid = 1'b1; dev_ddata = resp(32'h0000_3000);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk1("hold d_ready", tl_d_o.d_ready, 1'b0);
      chk1("hold h0 d_valid", tl_h_o[0].d_valid, 1'b1);
      chk1("hold h1 d_valid", tl_h_o[1].d_valid, 1'b0);
      chk1("hold h2 d_valid", tl_h_o[2].d_valid, 1'b0);
      step();
    end
    h_dready[0] = 1'b1;
    @(negedge clk);
    chk1("pop d_ready", tl_d_o.d_ready, 1'b1);
    chk1("full no bypass", tl_h_o[2].a_ready, 1'b0);
    step();
    dev_dvalid = 1'b0;
    @(negedge clk);
    chk1("grant after pop", tl_h_o[2].a_ready, 1'b1);
    chk32("grant after pop addr", tl_d_o.a_address, 32'h0000_3200);
    step();
    h_valid[2] = 1'b0;
    drain();

    // Random traffic.
    req_pct = 50; ar_pct = 70; dv_pct = 60; drdy_pct = 70;
    repeat (2000) begin
      drive_auto();
      step();
    end
    drain();

    // Reset mid-transaction with host 1 requesting.
    req_pct = 80; ar_pct = 60; dv_pct = 30; drdy_pct = 70;
    repeat (20) begin
      drive_auto();
      step();
    end
    #2;
    rst_n = 1'b0;
    h_valid[0] = 1'b0; h_valid[2] = 1'b0; h_valid[1] = 1'b1; dev_dvalid = 1'b0;
    dq.delete(); pend.delete();
    #1;
    chk1("reset drops a_valid", tl_d_o.a_valid, 1'b0);
    chk1("reset busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    h_valid[0] = 1'b1; h_addr[0] = 32'h0000_4000; h_addr[1] = 32'h0000_4100; dev_aready = 1'b1;
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk1("rr_ptr 0 after reset", tl_h_o[0].a_ready, 1'b1);
    chk32("post-reset address", tl_d_o.a_address, 32'h0000_4000);
    step();
    h_valid[0] = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
